// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: WB bypass, load-use stall/bubble, flush.
// Optional macro STALL_COUNT_EN adds a saturating stall_count output.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef STALL_COUNT_EN
  output logic [15:0]       stall_count,
`endif
  input  logic              if_id_valid,
  input  logic [DATA_W-1:0] if_id_instr,
  input  logic [DATA_W-1:0] if_id_pc,
  output logic [AW-1:0]     rf_read_reg1,
  output logic [AW-1:0]     rf_read_reg2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_reg_write,
  input  logic [AW-1:0]     wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall,
  output logic              id_ex_valid,
  output logic [DATA_W-1:0] id_ex_pc,
  output logic [DATA_W-1:0] id_ex_rs_data,
  output logic [DATA_W-1:0] id_ex_rt_data,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [AW-1:0]     id_ex_rs,
  output logic [AW-1:0]     id_ex_rt,
  output logic [AW-1:0]     id_ex_dest,
  output logic [3:0]        id_ex_op,
  output logic [2:0]        id_ex_funct,
  output logic              id_ex_reg_write,
  output logic              id_ex_mem_read,
  output logic              id_ex_mem_write,
  output logic              id_ex_alu_src,
  output logic              id_ex_branch
);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;

  logic [3:0]        op_s;
  logic [AW-1:0]     rs_s, rt_s, rd_s, dest_s;
  logic [2:0]        funct_s;
  logic [DATA_W-1:0] imm_s, rs_data_s, rt_data_s;
  logic              reg_write_raw_s, reg_write_s, mem_read_s, mem_write_s;
  logic              alu_src_s, branch_s, rt_used_s, hazard_s;

  assign op_s         = if_id_instr[15:12];
  assign rs_s         = if_id_instr[11:9];
  assign rt_s         = if_id_instr[8:6];
  assign rd_s         = if_id_instr[5:3];
  assign funct_s      = if_id_instr[2:0];
  assign imm_s        = {{(DATA_W-6){if_id_instr[5]}}, if_id_instr[5:0]};
  assign rf_read_reg1 = rs_s;
  assign rf_read_reg2 = rt_s;

  // Opcode decode into destination and control
  always_comb begin
    dest_s          = {AW{1'b0}};
    reg_write_raw_s = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    alu_src_s       = 1'b0;
    branch_s        = 1'b0;
    rt_used_s       = 1'b0;
    case (op_s)
      OP_R:    begin dest_s = rd_s; reg_write_raw_s = 1'b1; rt_used_s = 1'b1; end
      OP_ADDI: begin dest_s = rt_s; reg_write_raw_s = 1'b1; alu_src_s = 1'b1; end
      OP_LW:   begin dest_s = rt_s; reg_write_raw_s = 1'b1; alu_src_s = 1'b1; mem_read_s = 1'b1; end
      OP_SW:   begin mem_write_s = 1'b1; alu_src_s = 1'b1; rt_used_s = 1'b1; end
      OP_BEQ:  begin branch_s = 1'b1; rt_used_s = 1'b1; end
      default: begin dest_s = {AW{1'b0}}; end
    endcase
  end

  assign reg_write_s = reg_write_raw_s & (dest_s != {AW{1'b0}});

  // Operand A: r0 reads as zero, otherwise WB bypass wins over the register file
  always_comb begin
    if (rs_s == {AW{1'b0}}) rs_data_s = {DATA_W{1'b0}};
    else if (wb_reg_write && (wb_write_reg == rs_s)) rs_data_s = wb_write_data;
    else rs_data_s = rf_rd1;
  end

  // Operand B: same rule against rt
  always_comb begin
    if (rt_s == {AW{1'b0}}) rt_data_s = {DATA_W{1'b0}};
    else if (wb_reg_write && (wb_write_reg == rt_s)) rt_data_s = wb_write_data;
    else rt_data_s = rf_rd2;
  end

  assign hazard_s = if_id_valid && id_ex_valid && id_ex_mem_read &&
                    (id_ex_dest != {AW{1'b0}}) &&
                    ((id_ex_dest == rs_s) || (rt_used_s && (id_ex_dest == rt_s)));
  assign stall    = hazard_s & ~flush;

  // ID/EX register; flush or stall inserts a bubble while holding data fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid     <= 1'b0;
      id_ex_pc        <= {DATA_W{1'b0}};
      id_ex_rs_data   <= {DATA_W{1'b0}};
      id_ex_rt_data   <= {DATA_W{1'b0}};
      id_ex_imm       <= {DATA_W{1'b0}};
      id_ex_rs        <= {AW{1'b0}};
      id_ex_rt        <= {AW{1'b0}};
      id_ex_dest      <= {AW{1'b0}};
      id_ex_op        <= 4'h0;
      id_ex_funct     <= 3'h0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_alu_src   <= 1'b0;
      id_ex_branch    <= 1'b0;
    end else if (flush || hazard_s) begin
      id_ex_valid     <= 1'b0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_alu_src   <= 1'b0;
      id_ex_branch    <= 1'b0;
    end else begin
      id_ex_valid     <= if_id_valid;
      id_ex_pc        <= if_id_pc;
      id_ex_rs_data   <= rs_data_s;
      id_ex_rt_data   <= rt_data_s;
      id_ex_imm       <= imm_s;
      id_ex_rs        <= rs_s;
      id_ex_rt        <= rt_s;
      id_ex_dest      <= dest_s;
      id_ex_op        <= op_s;
      id_ex_funct     <= funct_s;
      id_ex_reg_write <= reg_write_s & if_id_valid;
      id_ex_mem_read  <= mem_read_s  & if_id_valid;
      id_ex_mem_write <= mem_write_s & if_id_valid;
      id_ex_alu_src   <= alu_src_s   & if_id_valid;
      id_ex_branch    <= branch_s    & if_id_valid;
    end
  end

`ifdef STALL_COUNT_EN
  // Saturating count of bubbles caused by load-use hazards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'h0000;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (stall_count checks under STALL_COUNT_EN).
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, if_id_valid, wb_reg_write, flush, stall;
  logic [15:0] if_id_instr, if_id_pc, rf_rd1, rf_rd2, wb_write_data;
  logic [2:0]  rf_read_reg1, rf_read_reg2, wb_write_reg;
  logic        id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src, id_ex_branch;
  logic [15:0] id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [2:0]  id_ex_rs, id_ex_rt, id_ex_dest, id_ex_funct;
  logic [3:0]  id_ex_op;
`ifdef STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  int vec  = 0;
  int miss = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
`ifdef STALL_COUNT_EN
    .stall_count(stall_count),
`endif
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .stall(stall), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_dest(id_ex_dest), .id_ex_op(id_ex_op),
    .id_ex_funct(id_ex_funct), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_alu_src(id_ex_alu_src), .id_ex_branch(id_ex_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_id_valid = 1'b0; if_id_instr = 16'h0000; if_id_pc = 16'h0000;
    rf_rd1 = 16'h0000; rf_rd2 = 16'h0000;
    wb_reg_write = 1'b0; wb_write_reg = 3'd0; wb_write_data = 16'h0000;
    tick; tick;
    chk("rst_valid", 16'(id_ex_valid), 16'h0000);
    chk("rst_pc", id_ex_pc, 16'h0000);
    chk("rst_stall", 16'(stall), 16'h0000);
    rst = 1'b0;

    // ADDI r2,r1,-3
    if_id_valid = 1'b1; if_id_instr = 16'h12BD; if_id_pc = 16'h0040;
    rf_rd1 = 16'h0010; rf_rd2 = 16'h7777;
    #1;
    chk("addi_rreg1", 16'(rf_read_reg1), 16'h0001);
    chk("addi_rreg2", 16'(rf_read_reg2), 16'h0002);
    tick;
    chk("addi_valid", 16'(id_ex_valid), 16'h0001);
    chk("addi_rs_data", id_ex_rs_data, 16'h0010);
    chk("addi_imm", id_ex_imm, 16'hFFFD);
    chk("addi_dest", 16'(id_ex_dest), 16'h0002);
    chk("addi_rt", 16'(id_ex_rt), 16'h0002);
    chk("addi_reg_write", 16'(id_ex_reg_write), 16'h0001);
    chk("addi_alu_src", 16'(id_ex_alu_src), 16'h0001);
    chk("addi_mem_read", 16'(id_ex_mem_read), 16'h0000);
    chk("addi_pc", id_ex_pc, 16'h0040);

    // asynchronous reset mid-cycle
    #2; rst = 1'b1; #1;
    chk("arst_valid", 16'(id_ex_valid), 16'h0000);
    chk("arst_rs_data", id_ex_rs_data, 16'h0000);
    chk("arst_imm", id_ex_imm, 16'h0000);
    chk("arst_reg_write", 16'(id_ex_reg_write), 16'h0000);
    chk("arst_pc", id_ex_pc, 16'h0000);
    chk("arst_stall", 16'(stall), 16'h0000);
    #1; rst = 1'b0;
    tick;
    chk("post_rst_valid", 16'(id_ex_valid), 16'h0001);
    chk("post_rst_imm", id_ex_imm, 16'hFFFD);

    // R-type r6 = r3 op r5 with WB bypass onto rs
    if_id_instr = 16'h0772; if_id_pc = 16'h0042; rf_rd1 = 16'h1111; rf_rd2 = 16'h2222;
    wb_reg_write = 1'b1; wb_write_reg = 3'd3; wb_write_data = 16'hBEEF;
    tick;
    chk("byp_rs_data", id_ex_rs_data, 16'hBEEF);
    chk("byp_rt_data", id_ex_rt_data, 16'h2222);
    chk("byp_dest", 16'(id_ex_dest), 16'h0006);
    chk("byp_funct", 16'(id_ex_funct), 16'h0002);
    chk("byp_reg_write", 16'(id_ex_reg_write), 16'h0001);
    chk("byp_alu_src", 16'(id_ex_alu_src), 16'h0000);

    // rs = r0 with WB to r0: zero, no bypass
    if_id_instr = 16'h0172; wb_write_reg = 3'd0;
    tick;
    chk("r0_rs_data", id_ex_rs_data, 16'h0000);
    chk("r0_rt_data", id_ex_rt_data, 16'h2222);
    // rt bypass while rs = r0
    wb_write_reg = 3'd5;
    tick;
    chk("r0b_rs_data", id_ex_rs_data, 16'h0000);
    chk("rtb_rt_data", id_ex_rt_data, 16'hBEEF);
    // matching address but write disabled
    if_id_instr = 16'h0772; wb_reg_write = 1'b0; wb_write_reg = 3'd3;
    tick;
    chk("nowb_rs_data", id_ex_rs_data, 16'h1111);
    wb_write_reg = 3'd0;

    // invalid instruction and unknown opcode
    if_id_valid = 1'b0; if_id_instr = 16'h12BD;
    tick;
    chk("inv_valid", 16'(id_ex_valid), 16'h0000);
    chk("inv_reg_write", 16'(id_ex_reg_write), 16'h0000);
    chk("inv_alu_src", 16'(id_ex_alu_src), 16'h0000);
    if_id_valid = 1'b1; if_id_instr = 16'h7FFF;
    tick;
    chk("nop_valid", 16'(id_ex_valid), 16'h0001);
    chk("nop_dest", 16'(id_ex_dest), 16'h0000);
    chk("nop_reg_write", 16'(id_ex_reg_write), 16'h0000);
    chk("nop_op", 16'(id_ex_op), 16'h0007);

    // load-use: LW r4 then R-type reading r4 as rs
    if_id_instr = 16'h2302;
    tick;
    chk("lw_mem_read", 16'(id_ex_mem_read), 16'h0001);
    chk("lw_dest", 16'(id_ex_dest), 16'h0004);
    if_id_instr = 16'h0970; #1;
    chk("lu_stall", 16'(stall), 16'h0001);
    tick;
    chk("lu_bubble_valid", 16'(id_ex_valid), 16'h0000);
    chk("lu_bubble_reg_write", 16'(id_ex_reg_write), 16'h0000);
    chk("lu_stall_cleared", 16'(stall), 16'h0000);
    tick;
    chk("lu_capture_valid", 16'(id_ex_valid), 16'h0001);
    chk("lu_capture_rs", 16'(id_ex_rs), 16'h0004);
    chk("lu_capture_dest", 16'(id_ex_dest), 16'h0006);

    // SW using r4 as rs stalls
    if_id_instr = 16'h2302;
    tick;
    if_id_instr = 16'h3940; #1;
    chk("sw_stall", 16'(stall), 16'h0001);
    tick;
    chk("sw_bubble_valid", 16'(id_ex_valid), 16'h0000);

    // ADDI with rt = r4 (written, not read) does not stall
    if_id_instr = 16'h2302;
    tick;
    if_id_instr = 16'h1301; #1;
    chk("addi_nostall", 16'(stall), 16'h0000);
    tick;
    chk("addi_ns_valid", 16'(id_ex_valid), 16'h0001);
    chk("addi_ns_dest", 16'(id_ex_dest), 16'h0004);

    // BEQ reading r4 as rt stalls
    if_id_instr = 16'h2302;
    tick;
    if_id_instr = 16'h4300; #1;
    chk("beq_stall", 16'(stall), 16'h0001);
    tick;
    chk("beq_bubble_branch", 16'(id_ex_branch), 16'h0000);

    // flush overrides stall
    if_id_instr = 16'h2302;
    tick;
    if_id_instr = 16'h0970; flush = 1'b1; #1;
    chk("flush_stall", 16'(stall), 16'h0000);
    tick;
    chk("flush_valid", 16'(id_ex_valid), 16'h0000);
    chk("flush_mem_read", 16'(id_ex_mem_read), 16'h0000);
    flush = 1'b0;

`ifdef STALL_COUNT_EN
    chk("stall_count3", stall_count, 16'h0003);
    if_id_instr = 16'h2302;
    tick;
    force dut.stall_count = 16'hFFFE;
    #1;
    release dut.stall_count;
    if_id_instr = 16'h0970;
    tick;
    chk("stall_count_max", stall_count, 16'hFFFF);
    if_id_instr = 16'h2302;
    tick;
    if_id_instr = 16'h0970;
    tick;
    chk("stall_count_sat", stall_count, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Instruction-decode stage and ID/EX pipeline register for the 16-bit, 8-register pipeline. It decodes the IF/ID instruction and drives the register-file read addresses. It bypasses same-cycle write-back data over the register-file read data, detects load-use hazards (stall plus bubble), and registers operands and control into EX on each clk rising edge. Upstream is the IF/ID register; downstream is the EX stage.

Parameters:
DATA_W, 16, datapath and instruction width; the instruction format below requires 16.
AW, 3, register address width (8 registers, r0 hardwired to zero).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  16  instruction: op[15:12] rs[11:9] rt[8:6] rd[5:3] funct[2:0]; imm6 = [5:0]
if_id_pc  in  16  PC of the instruction
rf_read_reg1  out  3  rs address to the register file (combinational)
rf_read_reg2  out  3  rt address to the register file (combinational)
rf_rd1  in  16  register-file ReadData1
rf_rd2  in  16  register-file ReadData2
wb_reg_write  in  1  WB write enable (same signal as the register-file write port)
wb_write_reg  in  3  WB destination
wb_write_data  in  16  WB data
flush  in  1  branch taken in EX; kill the ID instruction
stall  out  1  hold PC and IF/ID (combinational)
id_ex_valid  out  1  EX-stage instruction valid
id_ex_pc  out  16  registered PC
id_ex_rs_data  out  16  operand A
id_ex_rt_data  out  16  operand B / store data
id_ex_imm  out  16  sign-extended imm6
id_ex_rs, id_ex_rt, id_ex_dest  out  3 each  source and destination addresses (for the forwarding unit)
id_ex_op  out  4  opcode
id_ex_funct  out  3  R-type function
id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src, id_ex_branch  out  1 each  control

Behaviour:
- Reset: every registered output is 0 while rst is high, independent of clk; stall is 0.
- Decode (combinational):
  - op 0000 R-type: dest=rd, reg_write=1.
  - 0001 ADDI: dest=rt, reg_write=1, alu_src=1.
  - 0010 LW: dest=rt, reg_write=1, mem_read=1, alu_src=1.
  - 0011 SW: mem_write=1, alu_src=1, dest=0.
  - 0100 BEQ: branch=1, dest=0.
  - Any other opcode: NOP, all control 0, dest=0.
  - reg_write is forced to 0 when dest=0.
- rf_read_reg1=instr[11:9], rf_read_reg2=instr[8:6], always driven, even when invalid.
- Bypass operand A: if wb_reg_write and wb_write_reg!=0 and wb_write_reg==rs, A=wb_write_data; otherwise A=rf_rd1. Operand B uses the same rule against rt.
- Address 0 always yields 0, with no bypass.
- Imm: imm6 sign-extended to 16 bits (bit 5 replicated).
- Load-use stall: stall=1 when all of the following hold:
  - if_id_valid, id_ex_valid, id_ex_mem_read, and id_ex_dest!=0;
  - id_ex_dest==rs, or id_ex_dest==rt where rt is actually read (R-type, SW, BEQ).
- Per-edge priority:
  1. flush: id_ex_valid<=0 and all control <=0; stall output forced to 0.
  2. stall: bubble inserted (valid and control <=0; data fields don't-care but held); upstream holds.
  3. Otherwise: capture the decoded instruction; valid<=if_id_valid, with control zeroed if invalid.
- Latency: one cycle from IF/ID to ID/EX outputs. A stall lasts exactly one cycle per load-use pair, because the bubble clears the condition.
- Reset asserted mid-operation clears state immediately. The first edge after reset release captures normally.

Optional Feature:
STALL_COUNT_EN: defined adds output stall_count[15:0]. It increments on each edge where stall=1 and flush=0, saturates at 16'hFFFF, and is cleared by rst. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-cycle with valid outputs present -> all outputs 0 immediately, without waiting for an edge; stall=0.
- ADDI r2,r1,-3 (0x1 r1 r2 imm 0x3D) with rf_rd1=0x0010 -> next edge: rs_data=0x0010, imm=0xFFFD, dest=2, reg_write=1, alu_src=1.
- Bypass: R-type rs=r3, with wb_reg_write=1, wb_write_reg=3, wb_write_data=0xBEEF, rf_rd1=0x1111 -> rs_data=0xBEEF. Repeat with wb_write_reg=0 and rs=0 -> rs_data=0.
- Load-use: LW r4 in EX, then R-type in ID with rs=r4 -> stall=1 for one cycle, id_ex_valid=0 (bubble); next edge captures the R-type with stall=0. SW whose only use of r4 is rs also stalls; ADDI with rt=r4 (rt not read) does not stall.
- Flush and stall together: load-use condition present with flush=1 -> stall=0, id_ex_valid=0 next edge.
- STALL_COUNT_EN: 3 load-use stalls -> stall_count=3; preset near the limit -> saturates at 0xFFFF.
